// File: rtl/soc_glip_arb_pkg.sv
// soc_glip_arb_pkg: shared types, limits and header helpers for the GLIP packet arbiter.
package soc_glip_arb_pkg;

    localparam int MAX_N = 16;
    localparam int MAX_W = 64;

    typedef enum logic [1:0] {IDLE, HDR, BODY} state_e;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int arb_gw(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

    // Payload length carried in the low len_w bits of a header word.
    function automatic logic [MAX_W-1:0] glip_hdr_len(input logic [MAX_W-1:0] hdr, input int len_w);
        return hdr & ((MAX_W'(1) << len_w) - MAX_W'(1));
    endfunction

endpackage

// File: rtl/soc_glip_pkt_arbiter_if.sv
// soc_glip_pkt_arbiter_if: N requester word streams in, one GLIP fifo_out stream out.
//   in_valid/in_ready/in_data : per-requester handshake, requester i at in_data[i*WIDTH +: WIDTH]
//   out_valid/out_ready/out_data : single stream toward the GLIP bridge
//   master : the arbiter side, slave : the requesters plus the bridge
interface soc_glip_pkt_arbiter_if #(
    parameter int N     = 4,
    parameter int WIDTH = 16
);
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [N*WIDTH-1:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;

    modport master (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport slave (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/soc_glip_rr_picker.sv
// soc_glip_rr_picker: find the first set request at or above ptr, wrapping modulo N.
//   req   : request vector
//   ptr   : starting index of the search
//   found : any request set
//   idx   : winning index (0 when nothing is set)
module soc_glip_rr_picker #(
    parameter int N  = 4,
    parameter int GW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [GW-1:0] ptr,
    output logic          found,
    output logic [GW-1:0] idx
);
    assign found = |req;

    // Scan offsets from far to near so the nearest request to ptr is written last.
    always_comb begin
        idx = '0;
        for (int k = N - 1; k >= 0; k--)
            if (req[(int'(ptr) + k) % N]) idx = GW'((int'(ptr) + k) % N);
    end
endmodule

// File: rtl/soc_glip_pkt_arbiter.sv
// soc_glip_pkt_arbiter: packet-level round-robin sharing of one GLIP fifo_out channel.
//   clk, rst  : logic clock, asynchronous active-high reset
//   bus       : requester streams in, GLIP stream out (master modport)
//   busy      : a packet is in flight (HDR or BODY)
//   grant     : index of the current or most recent owner
//   pkt_done  : one-cycle pulse in the cycle after a packet's last word
module soc_glip_pkt_arbiter
    import soc_glip_arb_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int WIDTH = 16,
    parameter  int LEN_W = 8,
    localparam int GW    = arb_gw(N)
) (
    input  logic                   clk,
    input  logic                   rst,
    soc_glip_pkt_arbiter_if.master bus,
    output logic                   busy,
    output logic [GW-1:0]          grant,
    output logic                   pkt_done
);
    state_e            state_q, state_d;
    logic [GW-1:0]     rr_ptr_q, rr_ptr_d, grant_q, grant_d, pick_idx;
    logic [LEN_W-1:0]  remain_q, remain_d, len;
    logic              pkt_done_q, found, active, hs, last;
    logic [WIDTH-1:0]  sel_data;

    soc_glip_rr_picker #(.N(N), .GW(GW)) u_picker (
        .req   (bus.in_valid),
        .ptr   (rr_ptr_q),
        .found (found),
        .idx   (pick_idx)
    );

    // The owner's stream goes straight through; the grant stays fixed for the whole packet.
    assign active        = state_q != IDLE;
    assign sel_data      = bus.in_data[grant_q*WIDTH +: WIDTH];
    assign bus.out_valid = active & bus.in_valid[grant_q];
    assign bus.out_data  = sel_data;
    assign bus.in_ready  = active ? N'(bus.out_ready) << grant_q : '0;
    assign hs            = bus.out_valid & bus.out_ready;
    assign len           = LEN_W'(glip_hdr_len(MAX_W'(sel_data), LEN_W));
    assign last          = hs & (state_q == HDR ? len == '0 : remain_q == LEN_W'(1));

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        remain_d = remain_q;
        case (state_q)
            IDLE: if (found) begin
                grant_d = pick_idx;
                state_d = HDR;
            end
            HDR: if (hs) begin
                remain_d = len;
                state_d  = BODY;
            end
            BODY: if (hs) remain_d = remain_q - LEN_W'(1);
            default: state_d = IDLE;
        endcase
        // A finished packet always returns to IDLE, even a header-only one.
        if (last) begin
            state_d  = IDLE;
            rr_ptr_d = grant_q == GW'(N - 1) ? '0 : grant_q + GW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            remain_q   <= '0;
            pkt_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            remain_q   <= remain_d;
            pkt_done_q <= last;
        end

    assign busy     = active;
    assign grant    = grant_q;
    assign pkt_done = pkt_done_q;
endmodule

// File: tb/tb_soc_glip_pkt_arbiter.sv
// tb_soc_glip_pkt_arbiter: directed scoreboard bench for the GLIP packet arbiter.
module tb_soc_glip_pkt_arbiter;
    localparam int N = 4;
    localparam int W = 16;

    typedef struct packed {
        logic [1:0]  ch;
        logic [15:0] data;
        logic        first;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, pkt_done;
    logic [1:0] grant;

    always #5 clk = ~clk;

    soc_glip_pkt_arbiter_if #(.N(N), .WIDTH(W)) bus ();

    soc_glip_pkt_arbiter #(.N(N), .WIDTH(W), .LEN_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .busy     (busy),
        .grant    (grant),
        .pkt_done (pkt_done)
    );

    exp_t        exp_q[$];
    logic [15:0] mem [N][1024];
    int          head [N];
    int          tail [N];
    logic [N-1:0] gap_mask = '0;
    logic rand_ready = 1'b0, chk_gap = 1'b0, done_exp = 1'b0, have_prev = 1'b0;
    int checks = 0, passes = 0, cyc = 0, last_end = 0, hdr_cyc = 0;
    int busy_cnt = 0, done_cnt = 0, hs_cnt = 0, seq = 0, t0 = 0, n = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.in_valid[i] = head[i] < tail[i] && !(gap_mask[i] && $urandom_range(2) == 0);
            bus.in_data[i*W +: W] = mem[i][head[i]];
        end
        bus.out_ready = rand_ready ? 1'($urandom_range(1)) : 1'b1;
    endtask

    task automatic send(input int ch, input int len);
        logic [15:0] w;
        for (int k = 0; k <= len; k++) begin
            w = k == 0 ? {4'hA, 4'(ch), 8'(len)} : {4'(ch), 12'(seq)};
            seq++;
            mem[ch][tail[ch]] = w;
            tail[ch]++;
            exp_q.push_back('{ch: 2'(ch), data: w, first: k == 0, last: k == len});
        end
    endtask

    task automatic step();
        logic [N-1:0] pop;
        exp_t e;
        @(negedge clk);
        cyc++;
        chk("pkt_done", pkt_done, done_exp);
        done_exp = 1'b0;
        if (busy) busy_cnt++;
        if (pkt_done) done_cnt++;
        if (exp_q.size() == 0) chk("in_ready_idle", bus.in_ready, 0);
        else chk("in_ready_foreign", bus.in_ready & ~(4'b0001 << exp_q[0].ch), 0);
        pop = bus.in_valid & bus.in_ready;
        if (bus.out_valid && bus.out_ready) begin
            hs_cnt++;
            chk("word_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("out_data", bus.out_data, e.data);
                chk("grant", grant, e.ch);
                if (e.first) begin
                    if (chk_gap && have_prev) chk("idle_gap", cyc - last_end, 2);
                    hdr_cyc = cyc;
                end
                if (e.last) begin
                    done_exp  = 1'b1;
                    last_end  = cyc;
                    have_prev = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (pop[i]) head[i]++;
        drive();
    endtask

    task automatic run(input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || done_exp) && k < budget) begin
            step();
            k++;
        end
        chk("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pkt_done", pkt_done, 0);
        chk("rst_grant", grant, 0);
        rst = 1'b0;

        // Single packet from ch2, len 3.
        busy_cnt = 0;
        done_cnt = 0;
        t0 = cyc;
        send(2, 3);
        drive();
        run(20);
        repeat (2) step();
        chk("t1_latency", hdr_cyc - t0, 2);
        chk("t1_busy_cycles", busy_cnt, 4);
        chk("t1_done_pulses", done_cnt, 1);

        // Fairness: all channels busy, pointer sits at 3 after ch2.
        chk_gap = 1'b1;
        have_prev = 1'b0;
        for (int r = 0; r < 2; r++)
            for (int j = 0; j < N; j++) send((3 + j) % N, 1);
        drive();
        run(100);
        chk_gap = 1'b0;

        // Backpressure and owner bubbles on ch1 while ch3 and ch0 wait.
        rand_ready = 1'b1;
        gap_mask = 4'b0010;
        send(1, 4);
        drive();
        n = 0;
        while (!busy && n < 50) begin
            step();
            n++;
        end
        chk("t3_ch1_granted", busy, 1);
        send(3, 1);
        send(0, 2);
        drive();
        run(400);
        rand_ready = 1'b0;
        gap_mask = '0;

        // Zero-length header, then a maximum-length packet.
        hs_cnt = 0;
        send(2, 0);
        drive();
        run(20);
        chk("t4_zero_words", hs_cnt, 1);
        hs_cnt = 0;
        send(0, 255);
        drive();
        run(600);
        chk("t4_max_words", hs_cnt, 256);

        // Lone requester back to back; then the pointer must have wrapped to 0.
        chk_gap = 1'b1;
        have_prev = 1'b0;
        repeat (3) send(3, 2);
        drive();
        run(100);
        chk_gap = 1'b0;
        send(0, 1);
        send(3, 1);
        drive();
        run(50);
        send(1, 0);
        drive();
        run(20);

        // Reset during word 2 of a len-5 packet from ch2.
        hs_cnt = 0;
        send(2, 5);
        drive();
        n = 0;
        while (hs_cnt < 2 && n < 50) begin
            step();
            n++;
        end
        chk("t6_reached_word2", hs_cnt, 2);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_out_valid", bus.out_valid, 0);
        chk("t6_in_ready", bus.in_ready, 0);
        chk("t6_busy", busy, 0);
        chk("t6_grant", grant, 0);
        exp_q.delete();
        for (int i = 0; i < N; i++) head[i] = tail[i];
        done_exp = 1'b0;
        drive();
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(0, 1);
        send(3, 1);
        drive();
        run(50);
        repeat (3) step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
